// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: owns the PC, fetches one word at a time over a
// req/ack handshake, and hands instructions to decode over valid/ready.
module fetch_unit #(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         if_valid,
  input  logic         if_ready,
  output logic [31:0]  if_instr,
  output logic [N-1:0] if_pc,
  output logic [10:0]  if_op,
  output logic [31:0]  fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_reg;
  logic [N-1:0] pc_reg;
  logic [N-1:0] addr_reg;
  logic [N-1:0] if_pc_reg;
  logic [31:0]  instr_reg;
  logic [31:0]  count_reg;
  logic [N-1:0] target;
  logic         unused_low_bits;

  assign target          = {redirect_pc[N-1:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];

  // addr_reg is the address of the outstanding request; it is only rewritten
  // when no request is pending, so memory always sees a stable address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      addr_reg  <= RESET_PC;
      if_pc_reg <= '0;
      instr_reg <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= WAIT;
          if (redirect) begin
            pc_reg   <= target;
            addr_reg <= target;
          end else begin
            addr_reg <= pc_reg;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc_reg <= target;
            if (imem_ack) begin
              addr_reg <= target;
            end else begin
              state_reg <= DRAIN;
            end
          end else if (imem_ack) begin
            instr_reg <= imem_rdata;
            if_pc_reg <= pc_reg;
            pc_reg    <= pc_reg + N'(4);
            state_reg <= FULL;
          end
        end
        FULL: begin
          if (redirect) begin
            pc_reg    <= target;
            addr_reg  <= target;
            state_reg <= WAIT;
          end else if (if_ready) begin
            count_reg <= count_reg + 32'd1;
            addr_reg  <= pc_reg;
            state_reg <= WAIT;
          end
        end
        DRAIN: begin
          // The stale response is swallowed; the newest target wins.
          if (redirect) begin
            pc_reg <= target;
          end
          if (imem_ack) begin
            addr_reg  <= redirect ? target : pc_reg;
            state_reg <= WAIT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign imem_req    = (state_reg == WAIT) || (state_reg == DRAIN);
  assign imem_addr   = addr_reg;
  assign if_valid    = (state_reg == FULL);
  assign if_instr    = instr_reg;
  assign if_pc       = if_pc_reg;
  assign if_op       = instr_reg[31:21];
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand-written
// sequences for long memory waits and the absence of combinational paths.
module tb_fetch_unit;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         redirect;
  logic [N-1:0] redirect_pc;
  logic         if_valid;
  logic         if_ready;
  logic [31:0]  if_instr;
  logic [N-1:0] if_pc;
  logic [10:0]  if_op;
  logic [31:0]  fetch_count;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.N(N), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_op(if_op),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        rd;
    logic [63:0] rpc;
    logic        rdy;
    logic        req;
    logic        chka;
    logic [63:0] addr;
    logic        valid;
    logic [63:0] ipc;
    logic [31:0] instr;
    logic [10:0] op;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata, logic rd,
                              logic [63:0] rpc, logic rdy, logic req, logic chka,
                              logic [63:0] addr, logic valid, logic [63:0] ipc,
                              logic [31:0] instr, logic [10:0] op, logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.req = req; v.chka = chka; v.addr = addr; v.valid = valid; v.ipc = ipc;
    v.instr = instr; v.op = op; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic rd, input logic [63:0] rpc, input logic rdy);
    reset = rst; imem_ack = ack; imem_rdata = rdata;
    redirect = rd; redirect_pc = rpc; if_ready = rdy;
  endtask

  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);

    // rst ack rdata rd rpc rdy | req chka addr valid ipc instr op cnt
    // reset held three cycles
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0,0,32'h0,0,64'h0,0, 0,1,64'h0,0,64'h0,32'h0,11'h0,0));
    vq.push_back(mk(1,0,32'h0,0,64'h0,0, 1,1,64'h0,0,64'h0,32'h0,11'h0,0));
    // sequential zero-wait fetch
    vq.push_back(mk(1,1,32'hF840_0000,0,64'h0,1, 0,0,64'h0,1,64'h0,32'hF840_0000,11'h7C2,0));
    vq.push_back(mk(1,0,32'h0,0,64'h0,1, 1,1,64'h4,0,64'h0,32'hF840_0000,11'h7C2,1));
    vq.push_back(mk(1,1,32'hF800_0000,0,64'h0,1, 0,0,64'h0,1,64'h4,32'hF800_0000,11'h7C0,1));
    vq.push_back(mk(1,0,32'h0,0,64'h0,1, 1,1,64'h8,0,64'h4,32'hF800_0000,11'h7C0,2));
    vq.push_back(mk(1,1,32'hB400_0040,0,64'h0,1, 0,0,64'h0,1,64'h8,32'hB400_0040,11'h5A0,2));
    vq.push_back(mk(1,0,32'h0,0,64'h0,1, 1,1,64'hC,0,64'h8,32'hB400_0040,11'h5A0,3));
    vq.push_back(mk(1,1,32'h8B00_0000,0,64'h0,0, 0,0,64'h0,1,64'hC,32'h8B00_0000,11'h458,3));
    // backpressure
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1,0,32'h0,0,64'h0,0, 0,0,64'h0,1,64'hC,32'h8B00_0000,11'h458,3));
    vq.push_back(mk(1,0,32'h0,0,64'h0,1, 1,1,64'h10,0,64'hC,32'h8B00_0000,11'h458,4));
    // redirect in WAIT, ack three cycles late
    vq.push_back(mk(1,0,32'h0,1,64'h100,0, 1,1,64'h10,0,64'hC,32'h8B00_0000,11'h458,4));
    for (int i = 0; i < 2; i++)
      vq.push_back(mk(1,0,32'h0,0,64'h0,0, 1,1,64'h10,0,64'hC,32'h8B00_0000,11'h458,4));
    vq.push_back(mk(1,1,32'hDEAD_BEEF,0,64'h0,0, 1,1,64'h100,0,64'hC,32'h8B00_0000,11'h458,4));
    // redirect with simultaneous ack
    vq.push_back(mk(1,1,32'h1111_1111,1,64'h203,0, 1,1,64'h200,0,64'hC,32'h8B00_0000,11'h458,4));
    vq.push_back(mk(1,1,32'hAA00_0000,0,64'h0,0, 0,0,64'h0,1,64'h200,32'hAA00_0000,11'h550,4));
    // redirect in FULL with ready: squashed, not counted, low bits dropped
    vq.push_back(mk(1,0,32'h0,1,64'h103,1, 1,1,64'h100,0,64'h200,32'hAA00_0000,11'h550,4));
    vq.push_back(mk(1,1,32'h2222_2222,0,64'h0,0, 0,0,64'h0,1,64'h100,32'h2222_2222,11'h111,4));
    vq.push_back(mk(1,0,32'h0,0,64'h0,1, 1,1,64'h104,0,64'h100,32'h2222_2222,11'h111,5));
    // reset during DRAIN
    vq.push_back(mk(1,0,32'h0,1,64'h400,0, 1,1,64'h104,0,64'h100,32'h2222_2222,11'h111,5));
    vq.push_back(mk(0,0,32'h0,0,64'h0,0, 0,1,64'h0,0,64'h0,32'h0,11'h0,0));
    vq.push_back(mk(1,0,32'h0,0,64'h0,0, 1,1,64'h0,0,64'h0,32'h0,11'h0,0));
    // PC wrap at the top of the address space
    vq.push_back(mk(1,0,32'h0,1,TOP,0, 1,1,64'h0,0,64'h0,32'h0,11'h0,0));
    vq.push_back(mk(1,1,32'h0,0,64'h0,0, 1,1,TOP,0,64'h0,32'h0,11'h0,0));
    vq.push_back(mk(1,1,32'h9100_0000,0,64'h0,0, 0,0,64'h0,1,TOP,32'h9100_0000,11'h488,0));
    vq.push_back(mk(1,0,32'h0,0,64'h0,1, 1,1,64'h0,0,TOP,32'h9100_0000,11'h488,1));
    // redirect straight out of IDLE
    vq.push_back(mk(0,0,32'h0,0,64'h0,0, 0,1,64'h0,0,64'h0,32'h0,11'h0,0));
    vq.push_back(mk(1,0,32'h0,1,64'h40,0, 1,1,64'h40,0,64'h0,32'h0,11'h0,0));

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].ack, vq[i].rdata, vq[i].rd, vq[i].rpc, vq[i].rdy);
      @(posedge clk);
      #1;
      chk("imem_req", i, 64'(imem_req), 64'(vq[i].req));
      if (vq[i].chka) chk("imem_addr", i, imem_addr, vq[i].addr);
      chk("if_valid", i, 64'(if_valid), 64'(vq[i].valid));
      chk("if_pc", i, if_pc, vq[i].ipc);
      chk("if_instr", i, 64'(if_instr), 64'(vq[i].instr));
      chk("if_op", i, 64'(if_op), 64'(vq[i].op));
      chk("fetch_count", i, 64'(fetch_count), 64'(vq[i].cnt));
      $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h op=%h cnt=%0d",
               i, imem_req, imem_addr, if_valid, if_pc, if_op, fetch_count);
    end

    // Long memory wait: request must stay stable while unacknowledged.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, 32'h0, 0, 64'h0, 0);
      @(posedge clk);
      #1;
      chk("hold_req", 100 + i, 64'(imem_req), 64'h1);
      chk("hold_addr", 100 + i, imem_addr, 64'h40);
      $display("wait %0d: req=%0b addr=%h", i, imem_req, imem_addr);
    end
    @(negedge clk);
    drive(1, 1, 32'hF840_03E0, 0, 64'h0, 0);
    @(posedge clk);
    #1;
    chk("late_valid", 104, 64'(if_valid), 64'h1);
    chk("late_pc", 104, if_pc, 64'h40);
    chk("late_op", 104, 64'(if_op), 64'h7C2);
    $display("late ack: valid=%0b pc=%h op=%h", if_valid, if_pc, if_op);

    // Mid-cycle input changes must not reach any output.
    drive(1, 1, 32'h1234_5678, 0, 64'h0, 1);
    #1;
    chk("comb_valid", 105, 64'(if_valid), 64'h1);
    chk("comb_instr", 105, 64'(if_instr), 64'hF840_03E0);
    chk("comb_req", 105, 64'(imem_req), 64'h0);
    $display("comb: valid=%0b instr=%h req=%0b", if_valid, if_instr, imem_req);
    imem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("hs_count", 106, 64'(fetch_count), 64'h1);
    chk("hs_addr", 106, imem_addr, 64'h44);
    $display("handshake: cnt=%0d addr=%h", fetch_count, imem_addr);

    // Bounded wait for a fetch whose ack arrives on the third request cycle.
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      drive(1, (c == 2), 32'h8B1F_03E0, 0, 64'h0, 0);
      @(posedge clk);
      #1;
      if (if_valid) seen = 1'b1;
    end
    chk("bounded_valid", 107, 64'(seen), 64'h1);
    chk("bounded_pc", 107, if_pc, 64'h44);
    chk("bounded_op", 107, 64'(if_op), 64'h458);
    $display("bounded: seen=%0b pc=%h op=%h", seen, if_pc, if_op);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
